// File: rtl/univ_register.sv
// Parametrised general-purpose register: load, inc/dec, shift, rotate, sync clear, carry/zero flags.
// Define UNIV_REGISTER_BUS_EN to add the tri-state bus output and the bus-sourced LOAD.
module univ_register #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
`ifdef UNIV_REGISTER_BUS_EN
    input  logic             oe,
    input  logic             bus_ld,
    inout  wire  [WIDTH-1:0] bus,
`endif
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_SCLR = 3'b111;

    logic [WIDTH-1:0] q_nxt;
    logic             carry_nxt;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH:0]   inc_sum;

`ifdef UNIV_REGISTER_BUS_EN
    assign bus       = oe ? q : {WIDTH{1'bz}};
    assign load_data = bus_ld ? bus : d;
`else
    assign load_data = d;
`endif

    assign inc_sum = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        q_nxt     = q;
        carry_nxt = carry;
        case (op)
            OP_HOLD: begin
                q_nxt     = q;
                carry_nxt = carry;
            end
            OP_LOAD: begin
                q_nxt     = load_data;
                carry_nxt = 1'b0;
            end
            OP_INC: begin
                q_nxt     = inc_sum[WIDTH-1:0];
                carry_nxt = inc_sum[WIDTH];
            end
            OP_DEC: begin
                q_nxt     = q - {{(WIDTH-1){1'b0}}, 1'b1};
                carry_nxt = (q == '0);
            end
            OP_SHL: begin
                q_nxt     = {q[WIDTH-2:0], sin};
                carry_nxt = q[WIDTH-1];
            end
            OP_SHR: begin
                q_nxt     = {sin, q[WIDTH-1:1]};
                carry_nxt = q[0];
            end
            OP_ROL: begin
                q_nxt     = {q[WIDTH-2:0], q[WIDTH-1]};
                carry_nxt = q[WIDTH-1];
            end
            OP_SCLR: begin
                // Sync clear always goes to zero, independent of RESET_VAL.
                q_nxt     = '0;
                carry_nxt = 1'b0;
            end
            default: begin
                q_nxt     = q;
                carry_nxt = carry;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q     <= RESET_VAL;
            carry <= 1'b0;
        end else if (en) begin
            q     <= q_nxt;
            carry <= carry_nxt;
        end
    end

    assign zero = (q == '0);

endmodule

// File: tb/tb_univ_register.sv
// Self-checking bench for univ_register: directed vector table, multi-cycle reset/clear
// sequences, and a randomized run against an arithmetic reference model.
module tb_univ_register;

    localparam int         W    = 8;
    localparam logic [7:0] RVAL = 8'h3C;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, INC = 3'd2, DEC = 3'd3,
                           SHL  = 3'd4, SHR  = 3'd5, ROL = 3'd6, SCLR = 3'd7;

    logic         clk = 1'b0;
    logic         clr_n;
    logic         en;
    logic [2:0]   op;
    logic [W-1:0] d;
    logic         sin;
    logic [W-1:0] q;
    logic         carry;
    logic         zero;

`ifdef UNIV_REGISTER_BUS_EN
    logic         oe;
    logic         bus_ld;
    logic [W-1:0] bus_drv;
    logic         bus_drv_en;
    wire  [W-1:0] bus;
    assign bus = bus_drv_en ? bus_drv : {W{1'bz}};
`endif

    int checks = 0;
    int errors = 0;

    int mq;
    int mc;

    typedef struct {
        logic         en;
        logic [2:0]   op;
        logic [W-1:0] d;
        logic         sin;
        logic [W-1:0] eq;
        logic         ec;
    } vec_t;

    vec_t tbl[$];

    univ_register #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .en     (en),
        .op     (op),
        .d      (d),
        .sin    (sin),
`ifdef UNIV_REGISTER_BUS_EN
        .oe     (oe),
        .bus_ld (bus_ld),
        .bus    (bus),
`endif
        .q      (q),
        .carry  (carry),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [W-1:0] eq, input logic ec);
        check({name, ".q"}, {24'd0, q}, {24'd0, eq});
        check({name, ".carry"}, {31'd0, carry}, {31'd0, ec});
        check({name, ".zero"}, {31'd0, zero}, {31'd0, eq == 8'h00});
    endtask

    // Drive at the falling edge, let the rising edge act, sample 1 ns later.
    task automatic step(input logic e, input logic [2:0] o, input logic [W-1:0] dd, input logic s);
        @(negedge clk);
        en = e; op = o; d = dd; sin = s;
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input int e, input int o, input int dd, input int s);
        int t;
        if (e == 0) return;
        case (o)
            0: ;
            1: begin mq = dd; mc = 0; end
            2: begin t = mq + 1; mc = (t > 255) ? 1 : 0; mq = t % 256; end
            3: begin mc = (mq == 0) ? 1 : 0; mq = (mq + 255) % 256; end
            4: begin mc = mq / 128; mq = (mq * 2) % 256 + s; end
            5: begin mc = mq % 2; mq = mq / 2 + s * 128; end
            6: begin mc = mq / 128; mq = (mq * 2) % 256 + mc; end
            default: begin mq = 0; mc = 0; end
        endcase
    endfunction

    initial begin
        clr_n = 1'b1; en = 1'b0; op = HOLD; d = '0; sin = 1'b0;
`ifdef UNIV_REGISTER_BUS_EN
        oe = 1'b0; bus_ld = 1'b0; bus_drv = '0; bus_drv_en = 1'b0;
`endif

        // Async reset between edges, no clock
        #2 clr_n = 1'b0;
        #1 check_state("async_reset", RVAL, 1'b0);
        @(posedge clk); #1;
        check_state("reset_held", RVAL, 1'b0);
        @(negedge clk);
        clr_n = 1'b1; en = 1'b1; op = HOLD;
        @(posedge clk); #1;
        check_state("release_hold", RVAL, 1'b0);

        // Load gating
        step(1'b0, LOAD, 8'hAA, 1'b0);
        check_state("gated_load1", RVAL, 1'b0);
        step(1'b0, LOAD, 8'hAA, 1'b0);
        check_state("gated_load2", RVAL, 1'b0);
        step(1'b1, LOAD, 8'h55, 1'b0);
        check_state("load_55", 8'h55, 1'b0);

        tbl.push_back('{1'b1, LOAD, 8'hFE, 1'b0, 8'hFE, 1'b0});
        tbl.push_back('{1'b1, INC,  8'h00, 1'b0, 8'hFF, 1'b0});
        tbl.push_back('{1'b1, INC,  8'h00, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{1'b1, DEC,  8'h00, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b1, DEC,  8'h00, 1'b0, 8'hFE, 1'b0});
        tbl.push_back('{1'b0, SCLR, 8'h00, 1'b1, 8'hFE, 1'b0});
        tbl.push_back('{1'b1, LOAD, 8'h81, 1'b0, 8'h81, 1'b0});
        tbl.push_back('{1'b1, SHL,  8'h00, 1'b0, 8'h02, 1'b1});
        tbl.push_back('{1'b1, SHR,  8'h00, 1'b1, 8'h81, 1'b0});
        tbl.push_back('{1'b1, ROL,  8'h00, 1'b0, 8'h03, 1'b1});
        tbl.push_back('{1'b1, HOLD, 8'hEE, 1'b1, 8'h03, 1'b1});
        tbl.push_back('{1'b1, SHR,  8'h00, 1'b0, 8'h01, 1'b1});
        tbl.push_back('{1'b1, DEC,  8'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{1'b1, DEC,  8'h00, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b1, ROL,  8'h00, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b0, LOAD, 8'h00, 1'b0, 8'hFF, 1'b1});
        tbl.push_back('{1'b1, SHL,  8'h00, 1'b1, 8'hFF, 1'b1});
        tbl.push_back('{1'b1, SHR,  8'h00, 1'b0, 8'h7F, 1'b1});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].op, tbl[i].d, tbl[i].sin);
            check_state($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ec);
        end

        // Sync clear acts on the edge only
        step(1'b1, LOAD, 8'h77, 1'b0);
        check_state("load_77", 8'h77, 1'b0);
        @(negedge clk);
        op = SCLR; en = 1'b1;
        #1 check_state("sclr_before_edge", 8'h77, 1'b0);
        @(posedge clk); #1;
        check_state("sclr_after_edge", 8'h00, 1'b0);

        // Reset in the same cycle as a pending load
        @(negedge clk);
        op = LOAD; d = 8'h12; en = 1'b1;
        #2 clr_n = 1'b0;
        #1 check_state("reset_vs_load_async", RVAL, 1'b0);
        @(posedge clk); #1;
        check_state("reset_vs_load_edge", RVAL, 1'b0);
        @(negedge clk);
        op = HOLD; clr_n = 1'b1;
        @(posedge clk); #1;
        check_state("reset_release2", RVAL, 1'b0);

        // Randomized run against the reference model
        mq = int'(RVAL); mc = 0;
        for (int i = 0; i < 300; i++) begin
            logic         re, rs;
            logic [2:0]   ro;
            logic [W-1:0] rd;
            re = ($urandom_range(0, 4) != 0);
            ro = 3'($urandom_range(0, 7));
            rd = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            step(re, ro, rd, rs);
            model(int'(re), int'(ro), int'(rd), int'(rs));
            check_state($sformatf("rand%0d", i), 8'(mq), 1'(mc));
        end

`ifdef UNIV_REGISTER_BUS_EN
        step(1'b1, LOAD, 8'h5A, 1'b0);
        check_state("bus_load_5a", 8'h5A, 1'b0);
        oe = 1'b1;
        #1 check("bus_oe1", {24'd0, bus}, 32'h5A);
        oe = 1'b0;
        #1 check("bus_oe0_z", {31'd0, (bus === 8'hzz)}, 32'd1);
        @(negedge clk);
        bus_drv = 8'hC3; bus_drv_en = 1'b1; bus_ld = 1'b1;
        en = 1'b1; op = LOAD; d = 8'h00;
        @(posedge clk); #1;
        check_state("bus_ld_c3", 8'hC3, 1'b0);
        @(negedge clk);
        bus_drv_en = 1'b0; bus_ld = 1'b0; op = HOLD;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
